// File: rtl/cory_rgb_int2_pkg.sv
// cory_rgb_int2_pkg: shared state encoding and channel count for the x2 line interpolator
package cory_rgb_int2_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_PIX = 2'd2, S_REP = 2'd3} state_e;
  localparam int CH = 3;
endpackage

// File: rtl/cory_rgb_int2_avg2.sv
// cory_rgb_int2_avg2: round-half-up average of two channel values, widened by one bit so it cannot overflow
module cory_rgb_int2_avg2 #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  logic [N:0] s;
  assign s = {1'b0, a} + {1'b0, b} + (N+1)'(1);
  assign y = N'(s >> 1);
endmodule

// File: rtl/cory_rgb_int2.sv
// cory_rgb_int2: RGB x2 interpolation along a line, emitting p(k) then avg(p(k),p(k+1)), last pixel replicated
module cory_rgb_int2
  import cory_rgb_int2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_a_v,
  input  logic [3*N-1:0] i_a_d,
  input  logic           i_a_first,
  input  logic           i_a_last,
  output logic           o_a_r,
  output logic           o_z_v,
  output logic [3*N-1:0] o_z_d,
  output logic           o_z_first,
  output logic           o_z_last,
  input  logic           i_z_r
);
  localparam int W = 3*N;
  state_e state_q, state_d;
  logic z_v_q, z_v_d, z_first_q, z_first_d, z_last_q, z_last_d, hold_last_q, hold_last_d;
  logic [W-1:0] z_d_q, z_d_d, hold_q, hold_d, avg, ld_d;
  logic slot_free, acc, load, ld_first, ld_last, early_first;
  assign slot_free = !z_v_q || i_z_r;
  assign early_first = i_a_v && i_a_first;
  assign o_a_r = (state_q == S_IDLE) ? slot_free :
                 (state_q == S_WAIT) ? slot_free && !early_first : 1'b0;
  assign acc = i_a_v && o_a_r;
  assign o_z_v = z_v_q;
  assign o_z_d = z_d_q;
  assign o_z_first = z_first_q;
  assign o_z_last = z_last_q;
  genvar c;
  for (c = 0; c < CH; c++) begin : g_ch
    cory_rgb_int2_avg2 #(.N(N)) u_avg (
      .a(hold_q[c*N +: N]),
      .b(i_a_d[c*N +: N]),
      .y(avg[c*N +: N])
    );
  end
  // state and output registers; reset drops the held pixel and any pending output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      z_v_q       <= 1'b0;
      z_d_q       <= '0;
      z_first_q   <= 1'b0;
      z_last_q    <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_v_q       <= z_v_d;
      z_d_q       <= z_d_d;
      z_first_q   <= z_first_d;
      z_last_q    <= z_last_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
    end
  end
  // next state: an unterminated line (new first while waiting) is closed by replaying the held pixel as last
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc) state_d = i_a_last ? S_REP : S_WAIT;
      S_WAIT:  if (acc) state_d = S_PIX;
               else if (early_first && slot_free) state_d = S_IDLE;
      S_PIX:   if (slot_free) state_d = hold_last_q ? S_REP : S_WAIT;
      default: if (slot_free) state_d = S_IDLE;
    endcase
  end
  // output load selection and hold-register update; the output slot holds while stalled
  always_comb begin
    load        = 1'b0;
    ld_d        = hold_q;
    ld_first    = 1'b0;
    ld_last     = 1'b0;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    case (state_q)
      S_IDLE: if (acc) begin
        load     = 1'b1;
        ld_d     = i_a_d;
        ld_first = i_a_first;
        hold_d   = i_a_d;
      end
      S_WAIT: if (acc) begin
        load        = 1'b1;
        ld_d        = avg;
        hold_d      = i_a_d;
        hold_last_d = i_a_last;
      end else if (early_first && slot_free) begin
        load    = 1'b1;
        ld_last = 1'b1;
      end
      S_PIX: load = slot_free;
      default: begin
        load    = slot_free;
        ld_last = 1'b1;
      end
    endcase
    z_v_d     = load ? 1'b1 : slot_free ? 1'b0 : z_v_q;
    z_d_d     = load ? ld_d : z_d_q;
    z_first_d = load ? ld_first : z_first_q;
    z_last_d  = load ? ld_last : z_last_q;
  end
endmodule

// File: tb/tb_cory_rgb_int2.sv
// tb_cory_rgb_int2: scoreboard bench for the x2 line interpolator
module tb_cory_rgb_int2;
  localparam int N = 8;
  localparam int W = 3*N;
  logic clk = 1'b0, reset = 1'b1, i_a_v = 1'b0, i_a_first = 1'b0, i_a_last = 1'b0, i_z_r = 1'b1;
  logic [W-1:0] i_a_d = '0;
  logic o_a_r, o_z_v, o_z_first, o_z_last;
  logic [W-1:0] o_z_d;
  typedef struct packed {logic [W-1:0] d; logic f; logic l;} out_t;
  typedef struct {logic [W-1:0] p0; logic [W-1:0] p1; logic [W-1:0] mid;} vec_t;
  out_t exp_q[$];
  out_t e, prev;
  vec_t vecs[5];
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, t0;
  logic bp = 1'b0, stall_prev = 1'b0;

  cory_rgb_int2 #(.N(N)) dut (
    .clk(clk), .reset(reset), .i_a_v(i_a_v), .i_a_d(i_a_d), .i_a_first(i_a_first),
    .i_a_last(i_a_last), .o_a_r(o_a_r), .o_z_v(o_z_v), .o_z_d(o_z_d),
    .o_z_first(o_z_first), .o_z_last(o_z_last), .i_z_r(i_z_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 i_z_r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(o_z_v), 32'd1);
        chk("stall_data", 32'({o_z_d, o_z_first, o_z_last}), 32'(prev));
      end
      if (o_z_v && i_z_r) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none", {o_z_d, o_z_first, o_z_last});
        end else begin
          e = exp_q.pop_front();
          chk("out", 32'({o_z_d, o_z_first, o_z_last}), 32'(e));
        end
      end
      stall_prev = o_z_v && !i_z_r;
      prev = {o_z_d, o_z_first, o_z_last};
    end
  end

  task automatic push(logic [W-1:0] d, logic f, logic l);
    exp_q.push_back({d, f, l});
  endtask

  task automatic send_px(logic [W-1:0] d, logic f, logic l);
    int n = 0;
    i_a_v = 1'b1; i_a_d = d; i_a_first = f; i_a_last = l;
    @(negedge clk);
    while (!o_a_r && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_a_r) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel %h not accepted within 200 cycles", d);
    end else acc_cyc = cyc;
    @(posedge clk);
    #1;
    i_a_v = 1'b0; i_a_first = 1'b0; i_a_last = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d outputs missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk(name, 32'(o_z_v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{24'h0102FF, 24'h0201FE, 24'h0202FF};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 24'h808080};
    vecs[3] = '{24'h000000, 24'h010101, 24'h010101};
    vecs[4] = '{24'h102030, 24'h304050, 24'h203040};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", 32'(o_z_v), 32'd0);
    chk("rst_d", 32'(o_z_d), 32'd0);
    chk("rst_fl", 32'({o_z_first, o_z_last}), 32'd0);
    chk("rst_ar", 32'(o_a_r), 32'd1);
    reset = 1'b0;
    push(24'h102030, 1, 0); push(24'h203040, 0, 0); push(24'h304050, 0, 0);
    push(24'h405060, 0, 0); push(24'h506070, 0, 0); push(24'h506070, 0, 1);
    send_px(24'h102030, 1, 0);
    t0 = acc_cyc;
    send_px(24'h304050, 0, 0);
    send_px(24'h506070, 0, 1);
    chk("accept_spacing", 32'(acc_cyc - t0), 32'd3);
    wait_drain("line3_idle");
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].p0, 1, 0); push(vecs[i].mid, 0, 0);
      push(vecs[i].p1, 0, 0); push(vecs[i].p1, 0, 1);
      send_px(vecs[i].p0, 1, 0);
      send_px(vecs[i].p1, 0, 1);
      wait_drain("pair_idle");
    end
    bp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(24'h102030, 1, 0); push(24'h203040, 0, 0); push(24'h304050, 0, 0);
      push(24'h405060, 0, 0); push(24'h506070, 0, 0); push(24'h506070, 0, 1);
      send_px(24'h102030, 1, 0);
      send_px(24'h304050, 0, 0);
      send_px(24'h506070, 0, 1);
    end
    wait_drain("bp_idle");
    bp = 1'b0;
    @(posedge clk);
    #1;
    push(24'hABCDEF, 1, 0); push(24'hABCDEF, 0, 1);
    push(24'h112233, 1, 0); push(24'h223344, 0, 0); push(24'h334455, 0, 0); push(24'h334455, 0, 1);
    send_px(24'hABCDEF, 1, 1);
    send_px(24'h112233, 1, 0);
    send_px(24'h334455, 0, 1);
    wait_drain("single_idle");
    push(24'h000000, 1, 0); push(24'h010101, 0, 0); push(24'h020202, 0, 0);
    push(24'h020202, 0, 1); push(24'h101010, 1, 0); push(24'h101010, 0, 1);
    send_px(24'h000000, 1, 0);
    send_px(24'h020202, 0, 0);
    send_px(24'h101010, 1, 1);
    wait_drain("missing_last_idle");
    push(24'h102030, 1, 0);
    send_px(24'h102030, 1, 0);
    send_px(24'h304050, 0, 0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_v", 32'(o_z_v), 32'd0);
    chk("midreset_ar", 32'(o_a_r), 32'd1);
    reset = 1'b0;
    push(vecs[3].p0, 1, 0); push(vecs[3].mid, 0, 0);
    push(vecs[3].p1, 0, 0); push(vecs[3].p1, 0, 1);
    send_px(vecs[3].p0, 1, 0);
    send_px(vecs[3].p1, 0, 1);
    wait_drain("after_reset_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
